// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   RegAddrW / RegW / RegNum : default register-file geometry
//   WriteEnable / WriteDisable / ZeroWord : write-port constants
//   aux_entry_t : one queued auxiliary result {valid, addr, data}
package regfile_wb_arbiter_pkg;

   localparam int unsigned RegAddrW = 5;
   localparam int unsigned RegW     = 32;
   localparam int unsigned RegNum   = 2 ** RegAddrW;

   localparam logic            WriteEnable  = 1'b1;
   localparam logic            WriteDisable = 1'b0;
   localparam logic [RegW-1:0] ZeroWord     = '0;

   typedef struct packed {
      logic                valid;
      logic [RegAddrW-1:0] addr;
      logic [RegW-1:0]     data;
   } aux_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Buffer for auxiliary write-back results.
//   i_clk, i_rst (sync, active-low)
//   i_push, i_push_valid, i_push_addr, i_push_data : enqueue at tail
//   i_pop : retire the head entry
//   i_kill, i_kill_addr : invalidate every queued entry aimed at i_kill_addr
//   o_full, o_empty, o_head_valid, o_head_addr, o_head_data : queue state
//   o_busy : one bit per register with a valid queued entry
module wb_aux_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = RegAddrW,
   parameter int unsigned DATA_W = RegW
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_push,
   input  logic                 i_push_valid,
   input  logic [ADDR_W-1:0]    i_push_addr,
   input  logic [DATA_W-1:0]    i_push_data,
   input  logic                 i_pop,
   input  logic                 i_kill,
   input  logic [ADDR_W-1:0]    i_kill_addr,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_head_valid,
   output logic [ADDR_W-1:0]    o_head_addr,
   output logic [DATA_W-1:0]    o_head_data,
   output logic [2**ADDR_W-1:0] o_busy
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]  r_valid, w_valid_d;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PtrW-1:0]   r_rptr, r_wptr, w_rptr_d, w_wptr_d;
   logic [CntW-1:0]   r_count, w_count_d;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   always_comb begin
      w_valid_d = r_valid;
      w_rptr_d  = r_rptr;
      w_wptr_d  = r_wptr;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_kill && (r_addr[i] == i_kill_addr)) w_valid_d[i] = WriteDisable;
      end
      // Clearing valid on pop keeps stale slots out of the busy vector.
      if (i_pop) begin
         w_valid_d[r_rptr] = WriteDisable;
         w_rptr_d          = ptr_inc(r_rptr);
      end
      if (i_push) begin
         w_valid_d[r_wptr] = i_push_valid;
         w_wptr_d          = ptr_inc(r_wptr);
      end
      w_count_d = r_count + CntW'(i_push) - CntW'(i_pop);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_valid <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         r_valid <= w_valid_d;
         r_rptr  <= w_rptr_d;
         r_wptr  <= w_wptr_d;
         r_count <= w_count_d;
         if (i_push) begin
            r_addr[r_wptr] <= i_push_addr;
            r_data[r_wptr] <= i_push_data;
         end
      end
   end

   always_comb begin
      o_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i]) o_busy[r_addr[i]] = 1'b1;
      end
   end

   assign o_full       = (r_count == CntW'(DEPTH));
   assign o_empty      = (r_count == '0);
   assign o_head_valid = r_valid[r_rptr];
   assign o_head_addr  = r_addr[r_rptr];
   assign o_head_data  = r_data[r_rptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write-port master for the register file.
//   i_clk, i_rst (sync, active-low)
//   i_pipe_we/i_pipe_waddr/i_pipe_wdata : pipeline write-back, top priority
//   i_aux_valid/o_aux_ready/i_aux_waddr/i_aux_wdata : aux result handshake
//   o_rf_we/o_rf_waddr/o_rf_wdata : register-file write port
//   o_busy : registers with a pending aux write
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = RegAddrW,
   parameter int unsigned DATA_W = RegW
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pipe_we,
   input  logic [ADDR_W-1:0]    i_pipe_waddr,
   input  logic [DATA_W-1:0]    i_pipe_wdata,
   input  logic                 i_aux_valid,
   output logic                 o_aux_ready,
   input  logic [ADDR_W-1:0]    i_aux_waddr,
   input  logic [DATA_W-1:0]    i_aux_wdata,
   output logic                 o_rf_we,
   output logic [ADDR_W-1:0]    o_rf_waddr,
   output logic [DATA_W-1:0]    o_rf_wdata,
   output logic [2**ADDR_W-1:0] o_busy
);

   logic              w_pipe_real, w_push, w_push_valid, w_pop;
   logic              w_full, w_empty, w_head_valid;
   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;

   // Writes to r0 are discarded, so they never occupy the port.
   assign w_pipe_real  = i_rst && i_pipe_we && (i_pipe_waddr != '0);
   assign o_aux_ready  = i_rst && !w_full;
   assign w_push       = i_aux_valid && o_aux_ready && (i_aux_waddr != '0);
   // Same-cycle pipe write to the same register is the younger result.
   assign w_push_valid = !(w_pipe_real && (i_pipe_waddr == i_aux_waddr));
   // Invalid heads retire immediately; valid heads wait for a free port.
   assign w_pop        = i_rst && !w_empty && (!w_head_valid || !w_pipe_real);

   wb_aux_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_push       (w_push),
      .i_push_valid (w_push_valid),
      .i_push_addr  (i_aux_waddr),
      .i_push_data  (i_aux_wdata),
      .i_pop        (w_pop),
      .i_kill       (w_pipe_real),
      .i_kill_addr  (i_pipe_waddr),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_head_valid (w_head_valid),
      .o_head_addr  (w_head_addr),
      .o_head_data  (w_head_data),
      .o_busy       (o_busy)
   );

   always_comb begin
      o_rf_we    = WriteDisable;
      o_rf_waddr = '0;
      o_rf_wdata = DATA_W'(ZeroWord);
      if (w_pipe_real) begin
         o_rf_we    = WriteEnable;
         o_rf_waddr = i_pipe_waddr;
         o_rf_wdata = i_pipe_wdata;
      end else if (i_rst && !w_empty && w_head_valid) begin
         o_rf_we    = WriteEnable;
         o_rf_waddr = w_head_addr;
         o_rf_wdata = w_head_data;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int unsigned DEPTH  = 2;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst, pipe_we, aux_valid, aux_ready, rf_we;
   logic [ADDR_W-1:0] pipe_waddr, aux_waddr, rf_waddr;
   logic [DATA_W-1:0] pipe_wdata, aux_wdata, rf_wdata;
   logic [31:0]       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          valid;
      int unsigned addr;
      logic [31:0] data;
   } ent_t;
   ent_t q[$];

   // Outputs sampled at the last negedge, for directed spot checks.
   logic        s_we, s_ready;
   logic [4:0]  s_waddr;
   logic [31:0] s_wdata, s_busy;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_pipe_we    (pipe_we),
      .i_pipe_waddr (pipe_waddr),
      .i_pipe_wdata (pipe_wdata),
      .i_aux_valid  (aux_valid),
      .o_aux_ready  (aux_ready),
      .i_aux_waddr  (aux_waddr),
      .i_aux_wdata  (aux_wdata),
      .o_rf_we      (rf_we),
      .o_rf_waddr   (rf_waddr),
      .o_rf_wdata   (rf_wdata),
      .o_busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: compare every output against the model, then advance the model.
   task automatic cycle(input string phase);
      bit          real_w, pop;
      logic        e_we, e_ready;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata, e_busy;
      @(negedge clk);
      real_w  = rst && pipe_we && (pipe_waddr != 0);
      e_ready = rst && (q.size() < DEPTH);
      e_we = 0; e_waddr = 0; e_wdata = 0;
      if (real_w) begin
         e_we = 1; e_waddr = pipe_waddr; e_wdata = pipe_wdata;
      end else if (rst && q.size() > 0 && q[0].valid) begin
         e_we = 1; e_waddr = 5'(q[0].addr); e_wdata = q[0].data;
      end
      e_busy = 0;
      foreach (q[i]) if (q[i].valid) e_busy = e_busy | (32'd1 << q[i].addr);
      s_we = rf_we; s_ready = aux_ready; s_waddr = rf_waddr; s_wdata = rf_wdata; s_busy = busy;
      check({phase, ".rf_we"}, 64'(rf_we), 64'(e_we));
      check({phase, ".rf_waddr"}, 64'(rf_waddr), 64'(e_waddr));
      check({phase, ".rf_wdata"}, 64'(rf_wdata), 64'(e_wdata));
      check({phase, ".aux_ready"}, 64'(aux_ready), 64'(e_ready));
      check({phase, ".busy"}, 64'(busy), 64'(e_busy));
      @(posedge clk);
      if (!rst) begin
         q.delete();
      end else begin
         pop = q.size() > 0 && (!q[0].valid || !real_w);
         if (real_w) foreach (q[i]) if (q[i].addr == pipe_waddr) q[i].valid = 0;
         if (pop) void'(q.pop_front());
         if (aux_valid && e_ready && aux_waddr != 0)
            q.push_back('{valid: !(real_w && pipe_waddr == aux_waddr),
                          addr: aux_waddr, data: aux_wdata});
      end
      #1;
   endtask

   task automatic set_pipe(input logic we, input int unsigned a, input logic [31:0] d);
      pipe_we = we; pipe_waddr = 5'(a); pipe_wdata = d;
   endtask

   task automatic set_aux(input logic v, input int unsigned a, input logic [31:0] d);
      aux_valid = v; aux_waddr = 5'(a); aux_wdata = d;
   endtask

   initial begin
      rst = 0;
      set_pipe(0, 0, 0);
      set_aux(1, 4, 32'h4444);
      // Reset with an offered aux result
      cycle("rst0"); check("rst0.ready", 64'(s_ready), 0);
      cycle("rst1"); check("rst1.busy", 64'(s_busy), 0);
      rst = 1; set_aux(0, 0, 0);
      cycle("rel");  check("rel.ready", 64'(s_ready), 1);

      // Idle drain
      set_aux(1, 5, 32'hDEADBEEF);
      cycle("drain_acc");
      set_aux(0, 0, 0);
      cycle("drain_wr");
      check("drain.we", 64'(s_we), 1);
      check("drain.waddr", 64'(s_waddr), 5);
      check("drain.wdata", 64'(s_wdata), 64'h0DEADBEEF);
      check("drain.busy5", 64'(s_busy[5]), 1);
      cycle("drain_idle");
      check("drain.busy5_clr", 64'(s_busy[5]), 0);

      // Pipe priority over a queued entry
      set_aux(1, 3, 32'h11);
      cycle("prio_acc");
      set_aux(0, 0, 0);
      set_pipe(1, 7, 32'h22);
      for (int i = 0; i < 3; i++) begin
         cycle("prio_pipe");
         check("prio.pipe_addr", 64'(s_waddr), 7);
      end
      set_pipe(0, 0, 0);
      cycle("prio_aux");
      check("prio.aux_addr", 64'(s_waddr), 3);
      check("prio.aux_data", 64'(s_wdata), 64'h11);

      // Fill to DEPTH under continuous pipe traffic
      set_pipe(1, 8, 32'h88);
      set_aux(1, 1, 32'h101); cycle("full_p1");
      set_aux(1, 2, 32'h202); cycle("full_p2");
      set_aux(0, 0, 0);
      cycle("full_hold");
      check("full.ready", 64'(s_ready), 0);
      set_pipe(0, 0, 0);
      cycle("full_d1");
      check("full.d1_addr", 64'(s_waddr), 1);
      check("full.d1_ready", 64'(s_ready), 0);
      cycle("full_d2");
      check("full.d2_addr", 64'(s_waddr), 2);
      check("full.d2_ready", 64'(s_ready), 1);

      // WAW kill on the accept cycle
      set_aux(1, 9, 32'hAA);
      set_pipe(1, 9, 32'hBB);
      cycle("waw_acc");
      check("waw.pipe_data", 64'(s_wdata), 64'hBB);
      set_aux(0, 0, 0); set_pipe(0, 0, 0);
      cycle("waw_next");
      check("waw.busy9", 64'(s_busy[9]), 0);
      check("waw.no_we", 64'(s_we), 0);

      // Zero-address handling
      set_aux(1, 0, 32'h77);
      cycle("zero_aux");
      set_aux(1, 10, 32'h55);
      cycle("zero_aux_ok");
      check("zero.busy_none", 64'(s_busy), 0);
      set_aux(0, 0, 0);
      set_pipe(1, 0, 32'hFF);
      cycle("zero_pipe");
      check("zero.drain_addr", 64'(s_waddr), 10);
      check("zero.drain_data", 64'(s_wdata), 64'h55);
      set_pipe(0, 0, 0);

      // Reset mid-drain discards queued results
      set_pipe(1, 12, 32'hC);
      set_aux(1, 13, 32'hD); cycle("mid_p1");
      set_aux(1, 14, 32'hE); cycle("mid_p2");
      set_aux(0, 0, 0); set_pipe(0, 0, 0);
      cycle("mid_d1");
      rst = 0; cycle("mid_rst");
      rst = 1; cycle("mid_after");
      check("mid.we", 64'(s_we), 0);
      check("mid.busy", 64'(s_busy), 0);

      // Randomized traffic, addresses biased to a few registers for WAW hits
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(63) != 0);
         set_pipe(logic'($urandom_range(1)), $urandom_range(7), $urandom);
         set_aux(logic'($urandom_range(9) < 6), $urandom_range(7), $urandom);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
